// File: rtl/hdmi_video_timing_gen.sv
// rtl/hdmi_video_timing_gen.sv - raster timing generator (hsync/vsync/de, coordinates, frame/line strobes)
//
// Purpose: free-running video raster generator on the pixel clock. Stays idle
// until the PLL lock indication has passed a 2-flop synchroniser, then scans
// H_TOTAL x V_TOTAL positions and registers the sync/enable/coordinate outputs.
// Optional feature macro: TEST_PATTERN_EN (8 vertical colour bars on rgb_o).
//
// Ports:
//   refclk   in   pixel clock, sole clock
//   rst      in   synchronous active-high reset
//   locked   in   PLL lock, asynchronous to refclk
//   hsync_o  out  horizontal sync, active level HS_POL
//   vsync_o  out  vertical sync, active level VS_POL
//   de_o     out  data enable (active pixel)
//   x_o      out  horizontal position, CNT_W bits
//   y_o      out  vertical position, CNT_W bits
//   sof_o    out  pulse at pixel (0,0)
//   sol_o    out  pulse at x=0 of every line
//   rgb_o    out  24-bit {R,G,B} test pattern, 0 when the pattern is not built
module hdmi_video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             sof_o,
  output logic             sol_o,
  output logic [23:0]      rgb_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  // Lock synchroniser
  logic lock_meta_q, lock_meta_d;
  logic lock_s_q, lock_s_d;

  always_comb begin
    lock_meta_d = locked;
    lock_s_d    = lock_meta_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  // FSM: state register / next state / outputs
  state_t state_q, state_d;
  logic   cnt_run;

  always_ff @(posedge refclk) begin
    if (rst) state_q <= WAIT_LOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_s_q)  state_d = RUN;
      RUN:       if (!lock_s_q) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // Counters only advance while running with lock still present; the edge
  // that leaves RUN therefore clears them and idles the outputs at once.
  always_comb begin
    cnt_run = (state_q == RUN) && lock_s_q;
  end

  // Raster counters
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (cnt_run) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered outputs
  logic             active_px;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             sof_q, sof_d;
  logic             sol_q, sol_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  always_comb begin
    active_px = cnt_run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d   = ~HS_POL;
    vsync_d   = ~VS_POL;
    de_d      = 1'b0;
    sof_d     = 1'b0;
    sol_d     = 1'b0;
    x_d       = '0;
    y_d       = '0;
    if (cnt_run) begin
      de_d  = active_px;
      // vsync depends on v_cnt only, so its edges fall on h_cnt=0
      hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      sol_d = (h_cnt_q == '0);
      sof_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      x_d   = h_cnt_q;
      y_d   = v_cnt_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      sol_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      sol_q   <= sol_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign de_o    = de_q;
  assign sof_o   = sof_q;
  assign sol_o   = sol_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] rgb_q, rgb_d;

  // Bar index = number of bar boundaries already passed. Colour bits:
  // R = ~idx[1], G = ~idx[2], B = ~idx[0] yields W,Y,C,G,M,R,B,K.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= CNT_W'(i * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
    rgb_d = '0;
    if (active_px) rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end

  always_ff @(posedge refclk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;
`else
  assign rgb_o = 24'h0;
`endif

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// tb/tb_hdmi_video_timing_gen.sv - self-checking bench for hdmi_video_timing_gen on a reduced raster
module tb_hdmi_video_timing_gen;

  localparam int HA = 32, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 6,  VFP = 2, VSW = 3, VBP = 2;
  localparam int CW = 8;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam int HT = HA + HFP + HSW + HBP;  // 44
  localparam int VT = VA + VFP + VSW + VBP;  // 13

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          hsync_o, vsync_o, de_o, sof_o, sol_o;
  logic [CW-1:0] x_o, y_o;
  logic [23:0]   rgb_o;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  hdmi_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .locked (locked),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .de_o   (de_o),
    .x_o    (x_o),
    .y_o    (y_o),
    .sof_o  (sof_o),
    .sol_o  (sol_o),
    .rgb_o  (rgb_o)
  );

  // ---------------- behavioural model ----------------
  // Raster position is simply "cycles since the run began" folded by the
  // line and frame lengths; lock_s is the locked sample from two edges ago.
  function automatic logic [23:0] bar_color(input int x);
    int b;
    b = x / (HA / 8);
    if (b > 7) b = 7;
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  bit            lk_q[$];
  bit            m_running = 1'b0;
  bit            m_ok = 1'b0;
  bit            m_ls;
  int            m_n = 0;
  int            m_x, m_y;
  logic          e_hs, e_vs, e_de, e_sof, e_sol;
  logic [CW-1:0] e_x, e_y;
  logic [23:0]   e_rgb;

  always @(posedge refclk) begin
    m_ls = (lk_q.size() >= 2) ? lk_q[lk_q.size() - 2] : 1'b0;
    e_hs = ~HSP; e_vs = ~VSP; e_de = 0; e_sof = 0; e_sol = 0;
    e_x = '0; e_y = '0; e_rgb = '0;
    if (rst) begin
      lk_q.delete();
      m_running = 1'b0;
      m_n = 0;
      m_ok = 1'b1;
    end else begin
      if (m_running && m_ls) begin
        m_x   = m_n % HT;
        m_y   = (m_n / HT) % VT;
        e_de  = (m_x < HA) && (m_y < VA);
        e_hs  = (m_x >= HA + HFP && m_x < HA + HFP + HSW) ? HSP : ~HSP;
        e_vs  = (m_y >= VA + VFP && m_y < VA + VFP + VSW) ? VSP : ~VSP;
        e_sol = (m_x == 0);
        e_sof = (m_x == 0) && (m_y == 0);
        e_x   = CW'(m_x);
        e_y   = CW'(m_y);
`ifdef TEST_PATTERN_EN
        e_rgb = e_de ? bar_color(m_x) : 24'h0;
`endif
      end
      if (!m_running && m_ls)      begin m_running = 1'b1; m_n = 0; end
      else if (m_running && !m_ls) m_running = 1'b0;
      else if (m_running)          m_n++;
      lk_q.push_back(locked);
      if (lk_q.size() > 2) void'(lk_q.pop_front());
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Every clock advance goes through here; outputs are compared at negedge.
  task automatic tick();
    @(negedge refclk);
    if (m_ok) begin
      checks++;
      if ({hsync_o, vsync_o, de_o, sof_o, sol_o, x_o, y_o, rgb_o} !==
          {e_hs, e_vs, e_de, e_sof, e_sol, e_x, e_y, e_rgb}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got hs=%b vs=%b de=%b sof=%b sol=%b x=%0d y=%0d rgb=%h expected hs=%b vs=%b de=%b sof=%b sol=%b x=%0d y=%0d rgb=%h",
                 $time, hsync_o, vsync_o, de_o, sof_o, sol_o, x_o, y_o, rgb_o,
                 e_hs, e_vs, e_de, e_sof, e_sol, e_x, e_y, e_rgb);
      end
    end
  endtask

  function automatic bit is_idle();
    return !de_o && !sof_o && !sol_o && (hsync_o == ~HSP) && (vsync_o == ~VSP)
           && (x_o == '0) && (y_o == '0) && (rgb_o == 24'h0);
  endfunction

  task automatic wait_sof(input string name, input int exp_lat);
    int k;
    k = 0;
    while (!sof_o && k < 2000) begin tick(); k++; end
    check(name, k, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  int cyc, de_cnt, hs_cnt, vs_cnt, sol_cnt, hs_x0, vs_y0, de_xmax, k;
  logic [23:0] rgb_sof, rgb_x4;
  logic [23:0] exp_rgb0, exp_rgb4;

  initial begin
`ifdef TEST_PATTERN_EN
    exp_rgb0 = 24'hFFFFFF;
    exp_rgb4 = 24'hFFFF00;
`else
    exp_rgb0 = 24'h0;
    exp_rgb4 = 24'h0;
`endif
    rst = 1'b1;
    locked = 1'b1;
    repeat (4) tick();
    check("reset_idle", is_idle(), 1);
    check("reset_vsync_level", vsync_o, 1);

    // first sof: 2 sync + 1 FSM + 1 output register
    rst = 1'b0;
    wait_sof("first_sof_latency", 4);

    // one full frame from this sof to the next
    cyc = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; sol_cnt = 0;
    hs_x0 = -1; vs_y0 = -1; de_xmax = -1;
    rgb_sof = rgb_o; rgb_x4 = 24'hDEAD00;
    do begin
      if (de_o) begin
        de_cnt++;
        if (int'(x_o) > de_xmax) de_xmax = x_o;
      end
      if (hsync_o == HSP) begin hs_cnt++; if (hs_x0 < 0) hs_x0 = x_o; end
      if (vsync_o == VSP) begin vs_cnt++; if (vs_y0 < 0) vs_y0 = y_o; end
      if (sol_o) sol_cnt++;
      if (x_o == CW'(4) && y_o == '0) rgb_x4 = rgb_o;
      tick();
      cyc++;
    end while (!sof_o && cyc < 5000);
    check("frame_period", cyc, HT * VT);       // 572
    check("de_cycles_per_frame", de_cnt, 192); // 32 x 6
    check("hsync_cycles_per_frame", hs_cnt, 52);
    check("vsync_cycles_per_frame", vs_cnt, 132);
    check("sol_per_frame", sol_cnt, 13);
    check("hsync_start_x", hs_x0, 35);
    check("vsync_start_y", vs_y0, 8);
    check("de_last_x", de_xmax, 31);
    check("rgb_at_x0", rgb_sof, exp_rgb0);
    check("rgb_at_x4", rgb_x4, exp_rgb4);

    // lock loss mid-frame
    k = 0;
    while (!(y_o == CW'(3) && x_o == CW'(10)) && k < 2000) begin tick(); k++; end
    check("reach_y3_x10", (k < 2000) ? 1 : 0, 1);
    locked = 1'b0;
    k = 0;
    while (!is_idle() && k < 10) begin tick(); k++; end
    check("lock_loss_idle_cycles", k, 3);
    repeat ($urandom_range(5, 30)) tick();
    check("idle_while_unlocked", is_idle(), 1);
    locked = 1'b1;
    wait_sof("relock_sof_latency", 4);
    check("relock_origin", {x_o, y_o}, 0);

    // reset mid-frame: idle one cycle later, full restart latency after
    repeat ($urandom_range(100, 400)) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_frame_idle", is_idle(), 1);
    rst = 1'b0;
    wait_sof("post_rst_sof_latency", 4);

    // randomized lock/reset activity, checked by the model every cycle
    for (int it = 0; it < 30; it++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end else begin
        locked = (r > 2);
      end
      repeat ($urandom_range(1, 600)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
